// File: rtl/btn_ctrl.sv
// btn_ctrl - push-button peripheral on the memory-mapped read bus.
//
// Each of NUM_BTN channels runs a 2-flop synchroniser, a debounce filter,
// a sticky press-event bit and a saturating 8-bit press counter. Reads are
// registered (one-cycle latency). EVENT and COUNT registers clear on read.
//
// Optional feature macro: BTN_IRQ_EN
//   When defined, adds output irq and the read-only IRQ_MASK register at
//   word address 0xFF. When undefined, there is no irq port and 0xFF reads 0.
//
// Register map (word addresses):
//   0       EVENT  [NUM_BTN-1:0] sticky press events, clear-on-read
//   1       STATE  [NUM_BTN-1:0] debounced levels (1 = pressed)
//   2+i     COUNT[i] [7:0] saturating press count, clear-on-read
//   0xFF    IRQ_MASK (BTN_IRQ_EN only), all ones
//   other   reads 0
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   btn          raw asynchronous button pins
//   read_enable  read strobe
//   address      word address of the read
//   data_out     registered read data
//   irq          (BTN_IRQ_EN) registered OR of masked EVENT bits
module btn_ctrl #(
  parameter int NUM_BTN         = 2,
  parameter int ADDR_WIDTH      = 8,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_BTN-1:0]    btn,
  input  logic                  read_enable,
  input  logic [ADDR_WIDTH-1:0] address,
`ifdef BTN_IRQ_EN
  output logic                  irq,
`endif
  output logic [31:0]           data_out
);

  // Raw pin level that means "released".
  localparam logic [NUM_BTN-1:0] REL_LVL = (ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [15:0]        DB_LAST = 16'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0]         CNT_MAX = 8'hFF;

`ifdef BTN_IRQ_EN
  // Read-only mask with no write path, so it is a constant all-ones value.
  localparam logic [NUM_BTN-1:0] IRQ_MASK = '1;
`endif

  logic [NUM_BTN-1:0] r_sync1;
  logic [NUM_BTN-1:0] r_sync2;
  logic [NUM_BTN-1:0] r_stable;
  logic [NUM_BTN-1:0] r_event;
  logic [15:0]        r_db_cnt [NUM_BTN];
  logic [7:0]         r_count  [NUM_BTN];
  logic [31:0]        r_data;

  logic [NUM_BTN-1:0] w_sync;
  logic [NUM_BTN-1:0] w_accept;
  logic [NUM_BTN-1:0] w_rise;
  logic [NUM_BTN-1:0] w_clr_cnt;
  logic               w_clr_evt;
  logic [31:0]        w_rdata;

  // Synchroniser flops hold raw pin levels; normalise to active-high here.
  always_comb begin
    w_sync = r_sync2 ^ REL_LVL;
  end

  always_comb begin
    w_accept  = '0;
    w_clr_cnt = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      // Level change has persisted for DEBOUNCE_CYCLES consecutive samples.
      w_accept[i]  = (w_sync[i] != r_stable[i]) && (r_db_cnt[i] == DB_LAST);
      w_clr_cnt[i] = read_enable && (address == ADDR_WIDTH'(i + 2));
    end
  end

  always_comb begin
    w_rise    = w_accept & ~r_stable;
    w_clr_evt = read_enable && (address == ADDR_WIDTH'(0));
  end

  // Synchroniser and debounce filter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1  <= REL_LVL;
      r_sync2  <= REL_LVL;
      r_stable <= '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        r_db_cnt[i] <= '0;
      end
    end else begin
      r_sync1  <= btn;
      r_sync2  <= r_sync1;
      r_stable <= r_stable ^ w_accept;
      for (int i = 0; i < NUM_BTN; i++) begin
        if ((w_sync[i] == r_stable[i]) || w_accept[i]) begin
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + 16'd1;
        end
      end
    end
  end

  // Event and counter registers. A press landing on the same edge as a
  // clearing read survives the clear; the read itself returns the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_event <= '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        r_count[i] <= '0;
      end
    end else begin
      r_event <= (r_event & ~{NUM_BTN{w_clr_evt}}) | w_rise;
      for (int i = 0; i < NUM_BTN; i++) begin
        if (w_clr_cnt[i]) begin
          r_count[i] <= {7'd0, w_rise[i]};
        end else if (w_rise[i] && (r_count[i] != CNT_MAX)) begin
          r_count[i] <= r_count[i] + 8'd1;
        end
      end
    end
  end

  // Read multiplexer.
  always_comb begin
    w_rdata = '0;
    if (address == ADDR_WIDTH'(0)) begin
      w_rdata[NUM_BTN-1:0] = r_event;
    end else if (address == ADDR_WIDTH'(1)) begin
      w_rdata[NUM_BTN-1:0] = r_stable;
    end else begin
      for (int i = 0; i < NUM_BTN; i++) begin
        if (address == ADDR_WIDTH'(i + 2)) begin
          w_rdata[7:0] = r_count[i];
        end
      end
`ifdef BTN_IRQ_EN
      if (address == ADDR_WIDTH'(255)) begin
        w_rdata[NUM_BTN-1:0] = IRQ_MASK;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
    end else begin
      r_data <= read_enable ? w_rdata : 32'd0;
    end
  end

  assign data_out = r_data;

`ifdef BTN_IRQ_EN
  logic r_irq;

  // Follows EVENT by one cycle in both directions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= |(r_event & IRQ_MASK);
    end
  end

  assign irq = r_irq;
`endif

endmodule

// File: tb/tb_btn_ctrl.sv
module tb_btn_ctrl;

  localparam int NB = 2;
  localparam int DB = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NB-1:0] btn = '1;
  logic          read_enable = 1'b0;
  logic [7:0]    address = 8'd0;
  logic [31:0]   data_out;
`ifdef BTN_IRQ_EN
  logic          irq;
`endif

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  btn_ctrl #(
    .NUM_BTN        (NB),
    .ADDR_WIDTH     (8),
    .DEBOUNCE_CYCLES(DB),
    .ACTIVE_LOW     (1)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn        (btn),
    .read_enable(read_enable),
    .address    (address),
`ifdef BTN_IRQ_EN
    .irq        (irq),
`endif
    .data_out   (data_out)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a level change is accepted once DB consecutive
  // synchronised samples (pins delayed by two clocks) disagree with the
  // accepted level. Rising acceptances are presses.
  logic [NB-1:0] m_pd1, m_pd2, m_stable, m_event, m_s, m_rise;
  logic [DB-1:0] m_hist [NB];
  int            m_count [NB];
  logic [31:0]   m_data;
  logic          m_irq;

  task automatic model_reset();
    m_pd1    = '0;
    m_pd2    = '0;
    m_stable = '0;
    m_event  = '0;
    m_data   = 32'd0;
    m_irq    = 1'b0;
    for (int c = 0; c < NB; c++) begin
      m_hist[c]  = '0;
      m_count[c] = 0;
    end
  endtask

  task automatic model_edge();
    int          a;
    logic [31:0] rdv;
    a   = int'(address);
    rdv = 32'd0;
    if (read_enable) begin
      if (a == 0) rdv = 32'(m_event);
      else if (a == 1) rdv = 32'(m_stable);
      else if (a >= 2 && a < 2 + NB) rdv = 32'(m_count[a-2]);
`ifdef BTN_IRQ_EN
      else if (a == 255) rdv = 32'((1 << NB) - 1);
`endif
    end
    m_irq = |m_event;
    m_s   = m_pd2;
    m_pd2 = m_pd1;
    m_pd1 = ~btn;
    m_rise = '0;
    for (int c = 0; c < NB; c++) begin
      m_hist[c] = {m_hist[c][DB-2:0], m_s[c]};
      if (m_hist[c] == {DB{~m_stable[c]}}) begin
        m_stable[c] = ~m_stable[c];
        m_rise[c]   = m_stable[c];
      end
    end
    for (int c = 0; c < NB; c++) begin
      if (read_enable && a == 0) m_event[c] = 1'b0;
      if (m_rise[c]) m_event[c] = 1'b1;
      if (read_enable && a == 2 + c) m_count[c] = m_rise[c] ? 1 : 0;
      else if (m_rise[c]) m_count[c] = (m_count[c] >= 255) ? 255 : m_count[c] + 1;
    end
    m_data = rdv;
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    else model_reset();
    @(negedge clk);
    chk("data", data_out, m_data);
`ifdef BTN_IRQ_EN
    chk("irq", {31'd0, irq}, {31'd0, m_irq});
`endif
  endtask

  task automatic rd_chk(input string tag, input int a, input logic [31:0] exp);
    logic [31:0] d;
    read_enable = 1'b1;
    address     = 8'(a);
    step();
    d = data_out;
    read_enable = 1'b0;
    address     = 8'd0;
    chk(tag, d, exp);
  endtask

  logic [7:0] addr_tab [6];

  initial begin
    addr_tab = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'hFF};
    model_reset();
    repeat (3) step();
    chk("rst_data", data_out, 32'd0);
`ifdef BTN_IRQ_EN
    chk("rst_irq", {31'd0, irq}, 32'd0);
`endif
    rst_n = 1'b1;
    repeat (2) step();

    // Clean press on channel 0
    btn[0] = 1'b0;
    repeat (10) step();
    rd_chk("state_held", 1, 32'h1);
    rd_chk("evt_first", 0, 32'h1);
    rd_chk("evt_second", 0, 32'h0);
    rd_chk("cnt0_one", 2, 32'h1);
    btn[0] = 1'b1;
    repeat (8) step();
    rd_chk("state_rel", 1, 32'h0);

    // Glitch on channel 1
    btn[1] = 1'b0;
    repeat (2) step();
    btn[1] = 1'b1;
    repeat (8) step();
    rd_chk("glitch_evt", 0, 32'h0);
    rd_chk("glitch_cnt", 3, 32'h0);

    // Counter saturation
    repeat (300) begin
      btn[0] = 1'b0;
      repeat (5) step();
      btn[0] = 1'b1;
      repeat (5) step();
    end
    rd_chk("sat_cnt", 2, 32'hFF);
    rd_chk("sat_clr", 2, 32'h0);
    rd_chk("sat_evt", 0, 32'h1);

    // Press accepted on the same edge as an EVENT read
    btn[1] = 1'b0;
    repeat (5) step();
    rd_chk("coll_read", 0, 32'h0);
    rd_chk("coll_next", 0, 32'h2);
    rd_chk("coll_cnt", 3, 32'h1);

    // Reset mid-debounce, channel 1 held through it
    btn[0] = 1'b0;
    read_enable = 1'b1;
    address = 8'd1;
    repeat (2) step();
    read_enable = 1'b0;
    address = 8'd0;
    chk("pre_rst_state", data_out, 32'h2);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_async_data", data_out, 32'd0);
    step();
    rst_n = 1'b1;
    rd_chk("rst_evt_clear", 0, 32'h0);
    repeat (5) step();
    rd_chk("rst_reaccept", 0, 32'h3);
    btn = '1;
    repeat (8) step();

`ifdef BTN_IRQ_EN
    rd_chk("irq_mask", 255, 32'h3);
    btn[0] = 1'b0;
    repeat (6) step();
    chk("irq_before", {31'd0, irq}, 32'd0);
    step();
    chk("irq_rise", {31'd0, irq}, 32'd1);
    rd_chk("irq_evt", 0, 32'h1);
    chk("irq_hold", {31'd0, irq}, 32'd1);
    step();
    chk("irq_fall", {31'd0, irq}, 32'd0);
    btn = '1;
    repeat (8) step();
`else
    rd_chk("ff_zero", 255, 32'h0);
`endif
    rd_chk("addr4_zero", 4, 32'h0);

    // Randomised traffic against the model
    for (int k = 0; k < 3000; k++) begin
      for (int c = 0; c < NB; c++) begin
        if ($urandom_range(0, 5) == 0) btn[c] = ~btn[c];
      end
      if ($urandom_range(0, 2) == 0) begin
        read_enable = 1'b1;
        address     = addr_tab[$urandom_range(0, 5)];
      end else begin
        read_enable = 1'b0;
        address     = 8'd0;
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
